// File: rtl/energy_pkg.sv
// Shared types and default constants for the prepaid energy manager front end.
package energy_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } deb_state_t;

   localparam int DEB_CYCLES_DEF      = 4;
   localparam int PULSES_PER_UNIT_DEF = 10;
   localparam int CNT_W_DEF           = 10;
   localparam int MIN_GAP_DEF         = 16;

endpackage

// File: rtl/pulse_debouncer.sv
// Two-flop synchroniser followed by a level debouncer; accepted strobes once per
// debounced rising edge, registered on the cycle the FSM enters HIGH.
module pulse_debouncer
   import energy_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic accepted
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic          sync_p0, sync_p1;
   deb_state_t    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          accept_nxt;

   // Stage p0/p1: synchroniser; then state, run counter and registered strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0  <= 1'b0;
         sync_p1  <= 1'b0;
         state    <= IDLE;
         cnt      <= '0;
         accepted <= 1'b0;
      end else begin
         sync_p0  <= raw;
         sync_p1  <= sync_p0;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         accepted <= accept_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (sync_p1) begin
               state_nxt = RISE_CHK;
               cnt_nxt   = CW'(1);
            end
         end
         RISE_CHK: begin
            if (!sync_p1) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HIGH: begin
            if (!sync_p1) begin
               state_nxt = FALL_CHK;
               cnt_nxt   = CW'(1);
            end
         end
         FALL_CHK: begin
            if (sync_p1) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      accept_nxt = (state == RISE_CHK) && sync_p1 && (cnt == LAST);
   end

endmodule

// File: rtl/meter_pulse_conditioner.sv
// Debounces meter and date lines, prescales impulses into units and counts units per day.
// Optional over-rate tamper detection is built when TAMPER_DETECT_EN is defined.
module meter_pulse_conditioner
   import energy_pkg::*;
#(
   parameter int DEB_CYCLES      = DEB_CYCLES_DEF,
   parameter int PULSES_PER_UNIT = PULSES_PER_UNIT_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int MIN_GAP         = MIN_GAP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             meter_pulse_raw,
   input  logic             date_raw,
   input  logic             enable,
   output logic             unit_tick,
   output logic             day_tick,
   output logic [CNT_W-1:0] pulse_cnt,
   output logic [CNT_W-1:0] units_today,
   output logic             tamper
);

   logic meter_acc, date_acc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (x == '1) ? x : x + CNT_W'(1);
   endfunction

   pulse_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_meter_deb (
      .clk      (clk),
      .rst      (rst),
      .raw      (meter_pulse_raw),
      .accepted (meter_acc)
   );

   pulse_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_date_deb (
      .clk      (clk),
      .rst      (rst),
      .raw      (date_raw),
      .accepted (date_acc)
   );

   // Output stage: prescaler and per-day unit count; a unit coinciding with rollover starts the new day
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_cnt   <= '0;
         unit_tick   <= 1'b0;
         day_tick    <= 1'b0;
         units_today <= '0;
      end else begin
         unit_tick <= 1'b0;
         day_tick  <= date_acc;
         if (meter_acc && enable) begin
            if (pulse_cnt == CNT_W'(PULSES_PER_UNIT - 1)) begin
               pulse_cnt <= '0;
               unit_tick <= 1'b1;
            end else begin
               pulse_cnt <= pulse_cnt + CNT_W'(1);
            end
         end
         if (day_tick)
            units_today <= unit_tick ? CNT_W'(1) : '0;
         else if (unit_tick)
            units_today <= sat_inc(units_today);
      end
   end

`ifdef TAMPER_DETECT_EN
   localparam int GW = $clog2(MIN_GAP + 1);

   logic [GW-1:0] gap;
   logic          seen_first;
   logic          tamper_r;

   // Gap holds cycles since the last accepted impulse, saturating at MIN_GAP
   always_ff @(posedge clk) begin
      if (rst) begin
         gap        <= '0;
         seen_first <= 1'b0;
         tamper_r   <= 1'b0;
      end else if (meter_acc) begin
         gap        <= GW'(1);
         seen_first <= 1'b1;
         if (seen_first && (gap < GW'(MIN_GAP)))
            tamper_r <= 1'b1;
      end else if (gap < GW'(MIN_GAP)) begin
         gap <= gap + GW'(1);
      end
   end

   assign tamper = tamper_r;
`else
   // Constant 0 for every legal MIN_GAP; keeps the parameter referenced in this build
   assign tamper = (MIN_GAP < 0);
`endif

endmodule

// File: tb/tb_meter_pulse_conditioner.sv
// Directed self-checking bench for meter_pulse_conditioner (default and CNT_W=4 instances).
module tb_meter_pulse_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic meter_pulse_raw = 1'b0;
   logic date_raw = 1'b0;
   logic enable = 1'b1;

   logic       unit_tick, day_tick, tamper;
   logic [9:0] pulse_cnt, units_today;
   logic       unit_tick4, day_tick4, tamper4;
   logic [3:0] pulse_cnt4, units_today4;

   int n_checks = 0;
   int n_fail   = 0;
   int ut_cnt   = 0;
   int dt_cnt   = 0;
   int ut4_cnt  = 0;

   always #5 clk = ~clk;

   meter_pulse_conditioner #(
      .DEB_CYCLES(4), .PULSES_PER_UNIT(10), .CNT_W(10), .MIN_GAP(16)
   ) dut (
      .clk(clk), .rst(rst), .meter_pulse_raw(meter_pulse_raw), .date_raw(date_raw),
      .enable(enable), .unit_tick(unit_tick), .day_tick(day_tick),
      .pulse_cnt(pulse_cnt), .units_today(units_today), .tamper(tamper)
   );

   meter_pulse_conditioner #(
      .DEB_CYCLES(4), .PULSES_PER_UNIT(10), .CNT_W(4), .MIN_GAP(16)
   ) dut4 (
      .clk(clk), .rst(rst), .meter_pulse_raw(meter_pulse_raw), .date_raw(date_raw),
      .enable(enable), .unit_tick(unit_tick4), .day_tick(day_tick4),
      .pulse_cnt(pulse_cnt4), .units_today(units_today4), .tamper(tamper4)
   );

   always @(posedge clk) begin
      if (unit_tick)  ut_cnt  <= ut_cnt + 1;
      if (day_tick)   dt_cnt  <= dt_cnt + 1;
      if (unit_tick4) ut4_cnt <= ut4_cnt + 1;
   end

   task automatic pulse(input int hi, input int lo);
      meter_pulse_raw = 1'b1;
      repeat (hi) @(negedge clk);
      meter_pulse_raw = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic pulses(input int n);
      repeat (n) pulse(8, 8);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         meter_pulse_raw = ~meter_pulse_raw;
         date_raw = ~date_raw;
         @(negedge clk);
         n_checks++;
         if ({unit_tick, day_tick, pulse_cnt, units_today, tamper} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %h expected 0", i,
                     {unit_tick, day_tick, pulse_cnt, units_today, tamper});
         end
         n_checks++;
         if ({unit_tick4, day_tick4, pulse_cnt4, units_today4, tamper4} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs4 cycle %0d: got %h expected 0", i,
                     {unit_tick4, day_tick4, pulse_cnt4, units_today4, tamper4});
         end
      end
      rst = 1'b0;
      meter_pulse_raw = 1'b0;
      date_raw = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({unit_tick, day_tick, pulse_cnt, units_today, tamper} !== 23'd0) begin
         n_fail++;
         $display("FAIL after_release: got %h expected 0",
                  {unit_tick, day_tick, pulse_cnt, units_today, tamper});
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_ten_pulses();
      int ut0;
      ut0 = ut_cnt;
      pulses(9);
      n_checks++;
      if (pulse_cnt !== 10'd9) begin
         n_fail++;
         $display("FAIL nine_pulses_cnt: got %0d expected 9", pulse_cnt);
      end
      n_checks++;
      if (ut_cnt != ut0) begin
         n_fail++;
         $display("FAIL nine_pulses_no_tick: got %0d ticks expected 0", ut_cnt - ut0);
      end
      meter_pulse_raw = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (unit_tick !== (i == 7)) begin
            n_fail++;
            $display("FAIL unit_tick_latency edge %0d: got %b expected %b", i, unit_tick, (i == 7));
         end
      end
      meter_pulse_raw = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (ut_cnt - ut0 != 1) begin
         n_fail++;
         $display("FAIL ten_pulses_ticks: got %0d expected 1", ut_cnt - ut0);
      end
      n_checks++;
      if (pulse_cnt !== 10'd0) begin
         n_fail++;
         $display("FAIL ten_pulses_cnt: got %0d expected 0", pulse_cnt);
      end
      n_checks++;
      if (units_today !== 10'd1) begin
         n_fail++;
         $display("FAIL ten_pulses_units: got %0d expected 1", units_today);
      end
   endtask

   task automatic test_glitch();
      pulse(3, 10);
      n_checks++;
      if (pulse_cnt !== 10'd0) begin
         n_fail++;
         $display("FAIL glitch_rejected: got %0d expected 0", pulse_cnt);
      end
      pulse(5, 1);
      pulse(2, 8);
      n_checks++;
      if (pulse_cnt !== 10'd1) begin
         n_fail++;
         $display("FAIL dropout_counted_once: got %0d expected 1", pulse_cnt);
      end
   endtask

   task automatic test_day();
      int dt0;
      do_reset();
      pulses(50);
      n_checks++;
      if (units_today !== 10'd5) begin
         n_fail++;
         $display("FAIL units_before_day: got %0d expected 5", units_today);
      end
      dt0 = dt_cnt;
      date_raw = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (day_tick !== (i == 7)) begin
            n_fail++;
            $display("FAIL day_tick_latency edge %0d: got %b expected %b", i, day_tick, (i == 7));
         end
      end
      date_raw = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (dt_cnt - dt0 != 1) begin
         n_fail++;
         $display("FAIL day_tick_count: got %0d expected 1", dt_cnt - dt0);
      end
      n_checks++;
      if (units_today !== 10'd0) begin
         n_fail++;
         $display("FAIL units_cleared: got %0d expected 0", units_today);
      end
      pulses(19);
      n_checks++;
      if (pulse_cnt !== 10'd9 || units_today !== 10'd1) begin
         n_fail++;
         $display("FAIL pre_coincide: got cnt %0d units %0d expected cnt 9 units 1", pulse_cnt, units_today);
      end
      meter_pulse_raw = 1'b1;
      date_raw = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_checks++;
         if ({unit_tick, day_tick} !== ((i == 7) ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL coincide_ticks edge %0d: got %b expected %b", i, {unit_tick, day_tick},
                     ((i == 7) ? 2'b11 : 2'b00));
         end
      end
      meter_pulse_raw = 1'b0;
      date_raw = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (units_today !== 10'd1) begin
         n_fail++;
         $display("FAIL coincide_units: got %0d expected 1", units_today);
      end
   endtask

   task automatic test_saturate_enable();
      int ut40;
      do_reset();
      enable = 1'b1;
      pulses(200);
      n_checks++;
      if (units_today4 !== 4'd15) begin
         n_fail++;
         $display("FAIL units_saturate: got %0d expected 15", units_today4);
      end
      n_checks++;
      if (units_today !== 10'd20) begin
         n_fail++;
         $display("FAIL units_wide_twenty: got %0d expected 20", units_today);
      end
      pulses(3);
      enable = 1'b0;
      ut40 = ut4_cnt;
      pulses(10);
      n_checks++;
      if (pulse_cnt4 !== 4'd3) begin
         n_fail++;
         $display("FAIL disabled_hold: got %0d expected 3", pulse_cnt4);
      end
      n_checks++;
      if (ut4_cnt != ut40) begin
         n_fail++;
         $display("FAIL disabled_no_tick: got %0d ticks expected 0", ut4_cnt - ut40);
      end
      enable = 1'b1;
      pulses(1);
      n_checks++;
      if (pulse_cnt4 !== 4'd4) begin
         n_fail++;
         $display("FAIL reenabled_count: got %0d expected 4", pulse_cnt4);
      end
   endtask

   task automatic test_tamper();
      do_reset();
`ifdef TAMPER_DETECT_EN
      pulses(4);
      pulse(6, 6);
      n_checks++;
      if (tamper !== 1'b0) begin
         n_fail++;
         $display("FAIL tamper_slow: got %b expected 0", tamper);
      end
      pulse(6, 6);
      n_checks++;
      if (tamper !== 1'b1) begin
         n_fail++;
         $display("FAIL tamper_fast: got %b expected 1", tamper);
      end
      repeat (40) @(negedge clk);
      pulses(2);
      n_checks++;
      if (tamper !== 1'b1) begin
         n_fail++;
         $display("FAIL tamper_sticky: got %b expected 1", tamper);
      end
      do_reset();
      n_checks++;
      if (tamper !== 1'b0) begin
         n_fail++;
         $display("FAIL tamper_reset: got %b expected 0", tamper);
      end
`else
      pulse(6, 6);
      pulse(6, 6);
      pulse(6, 6);
      n_checks++;
      if ({tamper, tamper4} !== 2'b00) begin
         n_fail++;
         $display("FAIL tamper_absent: got %b expected 00", {tamper, tamper4});
      end
      n_checks++;
      if (pulse_cnt !== 10'd3) begin
         n_fail++;
         $display("FAIL fast_pulses_counted: got %0d expected 3", pulse_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_ten_pulses();
      test_glitch();
      test_day();
      test_saturate_enable();
      test_tamper();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
